// File: rtl/mandelbrot_pixel_scheduler.sv
// Mandelbrot frame scheduler: raster-order coordinate generation, dispatch to NUM_ENG
// iteration engines, and tag-ordered retirement into a ready/valid pixel stream.
module mandelbrot_pixel_scheduler #(
   parameter int NUM_ENG = 4,
   parameter int COORD_W = 32,
   parameter int ITER_W  = 16,
   parameter int DIM_W   = 12
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic [COORD_W-1:0]        real_min,
   input  logic [COORD_W-1:0]        imag_min,
   input  logic [COORD_W-1:0]        real_step,
   input  logic [COORD_W-1:0]        imag_step,
   input  logic [DIM_W-1:0]          width,
   input  logic [DIM_W-1:0]          height,
   output logic                      busy,
   output logic [NUM_ENG-1:0]        eng_start,
   output logic [COORD_W-1:0]        eng_c_re,
   output logic [COORD_W-1:0]        eng_c_im,
   input  logic [NUM_ENG-1:0]        eng_done,
   input  logic [NUM_ENG*ITER_W-1:0] eng_iter,
   output logic                      pixel_valid,
   input  logic                      pixel_ready,
   output logic [DIM_W-1:0]          pixel_x,
   output logic [DIM_W-1:0]          pixel_y,
   output logic [ITER_W-1:0]         pixel_iter,
   output logic                      pixel_last,
   output logic                      frame_done
);
   localparam int IDX_W = $clog2(NUM_ENG);
   localparam int TAG_W = IDX_W + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;
   typedef enum logic [1:0] {SL_FREE, SL_BUSY, SL_HELD} slot_e;

   state_e             state_q, state_d;
   logic [DIM_W-1:0]   width_q, width_d, height_q, height_d, x_q, x_d, y_q, y_d;
   logic [COORD_W-1:0] real_min_q, real_min_d, real_step_q, real_step_d, imag_step_q, imag_step_d;
   logic [COORD_W-1:0] c_re_q, c_re_d, c_im_q, c_im_d;
   logic [TAG_W-1:0]   disp_seq_q, disp_seq_d, ret_seq_q, ret_seq_d;

   slot_e              slot_st_q   [NUM_ENG];
   slot_e              slot_st_d   [NUM_ENG];
   logic [TAG_W-1:0]   slot_tag_q  [NUM_ENG];
   logic [TAG_W-1:0]   slot_tag_d  [NUM_ENG];
   logic [DIM_W-1:0]   slot_x_q    [NUM_ENG];
   logic [DIM_W-1:0]   slot_x_d    [NUM_ENG];
   logic [DIM_W-1:0]   slot_y_q    [NUM_ENG];
   logic [DIM_W-1:0]   slot_y_d    [NUM_ENG];
   logic [ITER_W-1:0]  slot_iter_q [NUM_ENG];
   logic [ITER_W-1:0]  slot_iter_d [NUM_ENG];

   logic               free_ok_s, dispatch_s, ret_ok_s, hs_s, last_disp_s, ret_last_s;
   logic [IDX_W-1:0]   disp_idx_s, ret_idx_s;
   logic [DIM_W-1:0]   x_last_s, y_last_s;

   assign x_last_s = width_q - DIM_W'(1);
   assign y_last_s = height_q - DIM_W'(1);

   // Scanning downward leaves the lowest matching index selected.
   always_comb begin
      free_ok_s  = 1'b0;
      disp_idx_s = '0;
      ret_ok_s   = 1'b0;
      ret_idx_s  = '0;
      for (int i = NUM_ENG - 1; i >= 0; i--) begin
         if (slot_st_q[i] == SL_FREE) begin
            free_ok_s  = 1'b1;
            disp_idx_s = IDX_W'(i);
         end else begin
            free_ok_s  = free_ok_s;
         end
         if (slot_st_q[i] == SL_HELD && slot_tag_q[i] == ret_seq_q) begin
            ret_ok_s  = 1'b1;
            ret_idx_s = IDX_W'(i);
         end else begin
            ret_ok_s  = ret_ok_s;
         end
      end
   end

   assign dispatch_s  = free_ok_s && (state_q == ST_RUN);
   assign hs_s        = ret_ok_s && pixel_ready;
   assign last_disp_s = dispatch_s && (x_q == x_last_s) && (y_q == y_last_s);
   assign ret_last_s  = ret_ok_s && (slot_x_q[ret_idx_s] == x_last_s) && (slot_y_q[ret_idx_s] == y_last_s);

   assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign frame_done  = (state_q == ST_DONE);
   assign eng_start   = dispatch_s ? ({{(NUM_ENG-1){1'b0}}, 1'b1} << disp_idx_s) : '0;
   assign eng_c_re    = dispatch_s ? c_re_q : '0;
   assign eng_c_im    = dispatch_s ? c_im_q : '0;
   assign pixel_valid = ret_ok_s;
   assign pixel_x     = ret_ok_s ? slot_x_q[ret_idx_s] : '0;
   assign pixel_y     = ret_ok_s ? slot_y_q[ret_idx_s] : '0;
   assign pixel_iter  = ret_ok_s ? slot_iter_q[ret_idx_s] : '0;
   assign pixel_last  = ret_last_s;

   // Frame FSM, raster scan and incremental coordinate generation.
   always_comb begin
      state_d     = state_q;
      width_d     = width_q;
      height_d    = height_q;
      real_min_d  = real_min_q;
      real_step_d = real_step_q;
      imag_step_d = imag_step_q;
      x_d         = x_q;
      y_d         = y_q;
      c_re_d      = c_re_q;
      c_im_d      = c_im_q;
      disp_seq_d  = dispatch_s ? disp_seq_q + TAG_W'(1) : disp_seq_q;
      ret_seq_d   = hs_s ? ret_seq_q + TAG_W'(1) : ret_seq_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               width_d     = width;
               height_d    = height;
               real_min_d  = real_min;
               real_step_d = real_step;
               imag_step_d = imag_step;
               x_d         = '0;
               y_d         = '0;
               c_re_d      = real_min;
               c_im_d      = imag_min;
               disp_seq_d  = '0;
               ret_seq_d   = '0;
               state_d     = (width == '0 || height == '0) ? ST_DONE : ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (dispatch_s) begin
               if (x_q == x_last_s) begin
                  x_d    = '0;
                  c_re_d = real_min_q;
                  y_d    = y_q + DIM_W'(1);
                  c_im_d = c_im_q + imag_step_q;
               end else begin
                  x_d    = x_q + DIM_W'(1);
                  c_re_d = c_re_q + real_step_q;
               end
               state_d = last_disp_s ? ST_DRAIN : ST_RUN;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (hs_s && ret_last_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Slot lifecycle: FREE -> BUSY on dispatch, BUSY -> HELD on done, HELD -> FREE on handshake.
   always_comb begin
      for (int i = 0; i < NUM_ENG; i++) begin
         slot_st_d[i]   = slot_st_q[i];
         slot_tag_d[i]  = slot_tag_q[i];
         slot_x_d[i]    = slot_x_q[i];
         slot_y_d[i]    = slot_y_q[i];
         slot_iter_d[i] = slot_iter_q[i];
         if (dispatch_s && disp_idx_s == IDX_W'(i)) begin
            slot_st_d[i]  = SL_BUSY;
            slot_tag_d[i] = disp_seq_q;
            slot_x_d[i]   = x_q;
            slot_y_d[i]   = y_q;
         end else if (slot_st_q[i] == SL_BUSY && eng_done[i]) begin
            slot_st_d[i]   = SL_HELD;
            slot_iter_d[i] = eng_iter[i*ITER_W +: ITER_W];
         end else if (hs_s && ret_idx_s == IDX_W'(i)) begin
            slot_st_d[i] = SL_FREE;
         end else begin
            slot_st_d[i] = slot_st_q[i];
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         width_q     <= '0;
         height_q    <= '0;
         real_min_q  <= '0;
         real_step_q <= '0;
         imag_step_q <= '0;
         x_q         <= '0;
         y_q         <= '0;
         c_re_q      <= '0;
         c_im_q      <= '0;
         disp_seq_q  <= '0;
         ret_seq_q   <= '0;
         for (int i = 0; i < NUM_ENG; i++) begin
            slot_st_q[i]   <= SL_FREE;
            slot_tag_q[i]  <= '0;
            slot_x_q[i]    <= '0;
            slot_y_q[i]    <= '0;
            slot_iter_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         width_q     <= width_d;
         height_q    <= height_d;
         real_min_q  <= real_min_d;
         real_step_q <= real_step_d;
         imag_step_q <= imag_step_d;
         x_q         <= x_d;
         y_q         <= y_d;
         c_re_q      <= c_re_d;
         c_im_q      <= c_im_d;
         disp_seq_q  <= disp_seq_d;
         ret_seq_q   <= ret_seq_d;
         for (int i = 0; i < NUM_ENG; i++) begin
            slot_st_q[i]   <= slot_st_d[i];
            slot_tag_q[i]  <= slot_tag_d[i];
            slot_x_q[i]    <= slot_x_d[i];
            slot_y_q[i]    <= slot_y_d[i];
            slot_iter_q[i] <= slot_iter_d[i];
         end
      end
   end
endmodule

// File: tb/tb_mandelbrot_pixel_scheduler.sv
// Directed bench for mandelbrot_pixel_scheduler with a latency-programmable engine model.
module tb_mandelbrot_pixel_scheduler;
   logic        clk, reset_n, start, pixel_ready;
   logic [31:0] f_rmin, f_imin, f_rstep, f_istep;
   logic [11:0] f_w, f_h;
   logic        busy, pixel_valid, pixel_last, frame_done;
   logic [3:0]  eng_start, eng_done, spur_req;
   logic [31:0] eng_c_re, eng_c_im;
   logic [63:0] eng_iter;
   logic [11:0] pixel_x, pixel_y;
   logic [15:0] pixel_iter;

   int errors = 0, checks = 0, cyc = 0, sc = 0;
   int lat [4];
   logic [31:0] d_re[$], d_im[$];
   logic [3:0]  d_mask[$];
   logic [11:0] p_x[$], p_y[$];
   logic [15:0] p_it[$];
   logic        p_last[$];
   int          hs_cyc[$];
   int          fd_cnt, fd_cyc, valid_cnt, first_valid, done0_cyc;

   mandelbrot_pixel_scheduler dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .real_min(f_rmin), .imag_min(f_imin), .real_step(f_rstep), .imag_step(f_istep),
      .width(f_w), .height(f_h), .busy(busy),
      .eng_start(eng_start), .eng_c_re(eng_c_re), .eng_c_im(eng_c_im),
      .eng_done(eng_done), .eng_iter(eng_iter),
      .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_iter(pixel_iter),
      .pixel_last(pixel_last), .frame_done(frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Engine model: a dispatch in cycle k yields a done pulse in cycle k+lat, iter = c_re[31:16]^c_im[31:16].
   initial begin
      int          cnt [4];
      logic [15:0] job [4];
      logic [3:0]  dv;
      for (int i = 0; i < 4; i++) begin
         cnt[i] = 0;
         job[i] = 16'd0;
      end
      eng_done = 4'd0;
      eng_iter = 64'd0;
      spur_req = 4'd0;
      forever begin
         @(posedge clk);
         #1;
         dv = spur_req;
         spur_req = 4'd0;
         for (int i = 0; i < 4; i++) begin
            if (cnt[i] > 0) begin
               cnt[i] = cnt[i] - 1;
               if (cnt[i] == 0) begin
                  dv[i] = 1'b1;
                  if (i == 0 && done0_cyc < 0) done0_cyc = cyc;
               end
            end
            if (eng_start[i]) begin
               cnt[i] = lat[i];
               job[i] = eng_c_re[31:16] ^ eng_c_im[31:16];
            end
         end
         eng_done = dv;
         for (int i = 0; i < 4; i++) eng_iter[i*16 +: 16] = job[i];
      end
   end

   // Observation log sampled mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (eng_start != 4'd0) begin
            d_re.push_back(eng_c_re);
            d_im.push_back(eng_c_im);
            d_mask.push_back(eng_start);
         end
         if (pixel_valid) begin
            valid_cnt = valid_cnt + 1;
            if (first_valid < 0) first_valid = cyc;
            if (pixel_ready) begin
               p_x.push_back(pixel_x);
               p_y.push_back(pixel_y);
               p_it.push_back(pixel_iter);
               p_last.push_back(pixel_last);
               hs_cyc.push_back(cyc);
            end
         end
         if (frame_done) begin
            fd_cnt = fd_cnt + 1;
            fd_cyc = cyc;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      d_re.delete(); d_im.delete(); d_mask.delete();
      p_x.delete(); p_y.delete(); p_it.delete(); p_last.delete(); hs_cyc.delete();
      fd_cnt = 0; fd_cyc = -1; valid_cnt = 0; first_valid = -1; done0_cyc = -1;
   endtask

   task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
      lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
   endtask

   task automatic start_frame(input logic [31:0] rmin, input logic [31:0] rstep,
                              input logic [31:0] imin, input logic [31:0] istep,
                              input logic [11:0] w, input logic [11:0] h);
      step(1);
      clear_log();
      f_rmin = rmin; f_rstep = rstep; f_imin = imin; f_istep = istep; f_w = w; f_h = h;
      start = 1'b1;
      sc = cyc;
      step(1);
      start = 1'b0;
   endtask

   task automatic wait_done();
      int  t0;
      logic seen;
      t0 = fd_cnt;
      seen = 1'b0;
      for (int i = 0; i < 2000 && !seen; i++) begin
         step(1);
         seen = (fd_cnt != t0);
      end
      check("frame_done_seen", 64'(seen), 64'd1);
      step(3);
   endtask

   task automatic check_frame(input int w, input int h);
      int          n;
      logic [31:0] er, ei;
      logic [15:0] eit;
      n = w * h;
      check("disp_count", 64'(d_re.size()), 64'(n));
      check("pix_count", 64'(p_x.size()), 64'(n));
      check("frame_done_count", 64'(fd_cnt), 64'd1);
      for (int k = 0; k < n; k++) begin
         er = f_rmin + 32'(k % w) * f_rstep;
         ei = f_imin + 32'(k / w) * f_istep;
         eit = er[31:16] ^ ei[31:16];
         if (k < d_re.size()) begin
            check($sformatf("c_re[%0d]", k), 64'(d_re[k]), 64'(er));
            check($sformatf("c_im[%0d]", k), 64'(d_im[k]), 64'(ei));
         end
         if (k < p_x.size()) begin
            check($sformatf("pix_x[%0d]", k), 64'(p_x[k]), 64'(k % w));
            check($sformatf("pix_y[%0d]", k), 64'(p_y[k]), 64'(k / w));
            check($sformatf("pix_iter[%0d]", k), 64'(p_it[k]), 64'(eit));
            check($sformatf("pix_last[%0d]", k), 64'(p_last[k]), 64'(k == n - 1));
         end
      end
   endtask

   function automatic logic any_out();
      return |{busy, eng_start, eng_c_re, eng_c_im, pixel_valid, pixel_x, pixel_y,
               pixel_iter, pixel_last, frame_done};
   endfunction

   initial begin
      logic        got, have_ref, stable;
      logic [39:0] ref_v;
      int          late_starts;
      reset_n = 1'b0; start = 1'b0; pixel_ready = 1'b1;
      f_rmin = 32'd0; f_imin = 32'd0; f_rstep = 32'd0; f_istep = 32'd0;
      f_w = 12'd0; f_h = 12'd0;
      set_lat(5, 5, 5, 5);
      clear_log();
      step(3);
      check("reset_outputs", 64'(any_out()), 64'd0);
      reset_n = 1'b1;
      step(2);
      check("idle_outputs", 64'(any_out()), 64'd0);

      // 3x2 frame, in-order replies, with a start pulse during RUN that must be ignored.
      start_frame(32'hE000_0000, 32'h0800_0000, 32'hF000_0000, 32'h1000_0000, 12'd3, 12'd2);
      check("busy_in_run", 64'(busy), 64'd1);
      step(2);
      start = 1'b1;
      step(1);
      start = 1'b0;
      wait_done();
      step(5);
      check_frame(3, 2);
      check("busy_after_frame", 64'(busy), 64'd0);

      // Reverse-order replies.
      set_lat(8, 6, 4, 2);
      start_frame(32'hE000_0000, 32'h0800_0000, 32'hF000_0000, 32'h1000_0000, 12'd3, 12'd2);
      wait_done();
      check_frame(3, 2);
      check("first_valid_after_eng0", 64'(first_valid), 64'(done0_cyc + 1));

      // Consumer stall of 20 cycles mid-frame.
      set_lat(3, 3, 3, 3);
      start_frame(32'hE000_0000, 32'h0400_0000, 32'hF000_0000, 32'h0800_0000, 12'd4, 12'd3);
      got = 1'b0;
      for (int i = 0; i < 500 && !got; i++) begin
         step(1);
         got = (p_x.size() >= 2);
      end
      check("stall_setup", 64'(got), 64'd1);
      pixel_ready = 1'b0;
      have_ref = 1'b0; stable = 1'b1; late_starts = 0; ref_v = 40'd0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (pixel_valid) begin
            if (!have_ref) begin
               ref_v = {pixel_x, pixel_y, pixel_iter};
               have_ref = 1'b1;
            end else if ({pixel_x, pixel_y, pixel_iter} !== ref_v) begin
               stable = 1'b0;
            end
         end
         if (i >= 10 && eng_start != 4'd0) late_starts = late_starts + 1;
      end
      check("stall_valid_seen", 64'(have_ref), 64'd1);
      check("stall_payload_stable", 64'(stable), 64'd1);
      check("stall_no_dispatch", 64'(late_starts), 64'd0);
      check("stall_valid_held", 64'(pixel_valid), 64'd1);
      pixel_ready = 1'b1;
      wait_done();
      check_frame(4, 3);

      // Zero width: immediate frame_done, nothing dispatched or emitted.
      set_lat(5, 5, 5, 5);
      start_frame(32'hE000_0000, 32'h0800_0000, 32'hF000_0000, 32'h1000_0000, 12'd0, 12'd2);
      wait_done();
      check("w0_done_cycle", 64'(fd_cyc), 64'(sc + 1));
      check("w0_frame_done_count", 64'(fd_cnt), 64'd1);
      check("w0_no_dispatch", 64'(d_re.size()), 64'd0);
      check("w0_no_valid", 64'(valid_cnt), 64'd0);

      // Spurious done to a free slot.
      step(1);
      clear_log();
      spur_req = 4'b0100;
      step(6);
      check("spurious_no_pixel", 64'(valid_cnt), 64'd0);

      // Reset mid-frame, stale engine pulses, then a fresh frame.
      start_frame(32'hE000_0000, 32'h0800_0000, 32'hF000_0000, 32'h1000_0000, 12'd3, 12'd2);
      step(8);
      reset_n = 1'b0;
      #1;
      check("midframe_reset_outputs", 64'(any_out()), 64'd0);
      step(2);
      reset_n = 1'b1;
      clear_log();
      step(10);
      check("post_reset_no_dispatch", 64'(d_re.size()), 64'd0);
      check("post_reset_no_valid", 64'(valid_cnt), 64'd0);
      start_frame(32'hE000_0000, 32'h0800_0000, 32'hF000_0000, 32'h1000_0000, 12'd3, 12'd2);
      wait_done();
      check_frame(3, 2);

      // Single-pixel frame.
      start_frame(32'h1000_0000, 32'h0800_0000, 32'hE000_0000, 32'h1000_0000, 12'd1, 12'd1);
      wait_done();
      check_frame(1, 1);
      if (d_mask.size() > 0) check("one_px_engine0", 64'(d_mask[0]), 64'd1);
      if (hs_cyc.size() > 0) check("one_px_done_cycle", 64'(fd_cyc), 64'(hs_cyc[0] + 1));

      step(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mandelbrot_pixel_scheduler.md
Name: mandelbrot_pixel_scheduler

Overview:
- Sequences one frame of Mandelbrot rendering across NUM_ENG parallel escape-time iteration engines.
- Scans the frame in raster order and generates each pixel's complex coordinate c incrementally (no multiply/divide).
- Dispatches each pixel to an idle engine and collects the iteration counts.
- Re-emits results as an in-order raster pixel stream with ready/valid backpressure toward the colour-mapping/output stage.

Parameters:
NUM_ENG, 4, number of iteration engines (power of two, 2..16)
COORD_W, 32, signed fixed-point coordinate width (Q4.28)
ITER_W, 16, iteration count width
DIM_W, 12, width/height/x/y counter width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  begin frame; sampled only in IDLE
real_min  in  COORD_W  c_re at x=0
imag_min  in  COORD_W  c_im at y=0
real_step  in  COORD_W  c_re increment per column
imag_step  in  COORD_W  c_im increment per row
width  in  DIM_W  columns per frame
height  in  DIM_W  rows per frame
busy  out  1  high in RUN/DRAIN
eng_start  out  NUM_ENG  one-cycle job pulse, one bit per engine
eng_c_re  out  COORD_W  broadcast c_re; valid in the cycle any eng_start bit is high
eng_c_im  out  COORD_W  broadcast c_im; same validity
eng_done  in  NUM_ENG  one-cycle completion pulse per engine
eng_iter  in  NUM_ENG*ITER_W  engine i's count in bits [i*ITER_W +: ITER_W]; valid with eng_done[i]
pixel_valid  out  1  output pixel available
pixel_ready  in  1  consumer accepts
pixel_x  out  DIM_W  column of output pixel
pixel_y  out  DIM_W  row of output pixel
pixel_iter  out  ITER_W  iteration count
pixel_last  out  1  final pixel of frame (qualified by pixel_valid)
frame_done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset values of all outputs, and the outputs on leaving reset: 0. Reset clears engine slot states, counters and FSM → IDLE. Reset mid-frame abandons the frame; engine pulses after reset are ignored until the next dispatch.
- FSM: IDLE → RUN on start. Latch all frame inputs; x=y=0; c_re=real_min; c_im=imag_min; dispatch seq and retire seq = 0.
- If width==0 or height==0: IDLE → DONE; frame_done pulses the next cycle; no dispatch or pixels.
- RUN → DRAIN after the last pixel (x=width-1, y=height-1) is dispatched.
- DRAIN → DONE when the last pixel handshakes (pixel_valid & pixel_ready).
- DONE: frame_done=1 for one cycle → IDLE.
- start is ignored outside IDLE.
- Slot states per engine: FREE, BUSY, HELD. Each slot stores a tag (clog2(NUM_ENG)+1 bits), x, y and iter.
- Dispatch (RUN, at most one per cycle) to the lowest-index FREE engine:
  - eng_start[i]=1 and eng_c_re/eng_c_im = current c.
  - Store the tag (= dispatch seq mod 2^(clog2(NUM_ENG)+1)) and x, y; slot → BUSY.
  - Advance x; c_re += real_step.
  - At x=width-1: x=0, c_re=real_min, y+=1, c_im += imag_step.
  - Coordinate adds wrap modulo 2^COORD_W.
- No FREE engine: stall; eng_start=0.
- eng_done[i] with slot i BUSY: capture iter; slot → HELD. eng_done to a non-BUSY slot is ignored.
- Retirement: the HELD slot whose tag == retire seq drives pixel_x/y/iter and pixel_valid=1.
  - pixel_valid rises in the cycle after the capture.
  - Payload holds stable while pixel_valid & !pixel_ready.
  - On handshake: slot → FREE, retire seq += 1.
  - The freed engine is dispatchable from the following cycle, not the same cycle.
- Outstanding jobs ≤ NUM_ENG, so tags are unique among non-FREE slots.
- Simultaneous events are all legal in one cycle: a dispatch, multiple eng_done pulses, and a retirement (on different slots).
- pixel_last=1 when the presented pixel is (width-1, height-1).
- Throughput cap: one pixel per cycle.

Test Plan:
- NUM_ENG=4, width=3, height=2, real_min=-2.0, real_step=0.5, imag_min=-1.0, imag_step=1.0, engines reply in order after 5 cycles → eng_c_re sequence -2.0, -1.5, -1.0, -2.0, -1.5, -1.0; eng_c_im -1.0 ×3 then 0.0 ×3; pixels (0,0)…(2,1) in order; pixel_last on (2,1); one frame_done pulse.
- Engines reply in reverse (engine 3 first, latencies 8, 6, 4, 2) → output still raster order; pixel_valid low until engine 0's pixel is held.
- pixel_ready held low 20 cycles mid-frame → payload stable; all engines end HELD; no eng_start while stalled; resumes with no loss or duplication.
- width=0 → frame_done pulse one cycle after start; no eng_start or pixel_valid. start asserted during RUN → ignored.
- Spurious eng_done[2] while slot 2 FREE → no pixel emitted. reset_n low mid-frame → all outputs 0 next cycle; a fresh start renders correctly.
- width=1, height=1 → single dispatch to engine 0; pixel (0,0) with pixel_last=1; frame_done one cycle after the handshake.
